// File: rtl/seq_pkg.sv
// Shared types and constants for the phase_sequencer traffic-light controller:
// state encoding, lamp patterns, default phase durations and phase ordering.
package seq_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        EW_G  = 3'd2,
        EW_Y  = 3'd3,
        EMERG = 3'd4
    } state_t;

    // Lamp bit order is {R,Y,G}.
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int DEF_TICK_DIV  = 1000000;
    localparam int DEF_NS_GREEN  = 15;
    localparam int DEF_NS_YELLOW = 5;
    localparam int DEF_EW_GREEN  = 15;
    localparam int DEF_EW_YELLOW = 5;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_G:    return NS_Y;
            NS_Y:    return EW_G;
            EW_G:    return EW_Y;
            default: return NS_G;
        endcase
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while run is high;
// clr restarts the second from zero and suppresses any tick due that cycle.
module tick_prescaler #(
    parameter int  TICK_DIV = 1000000,
    localparam int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    assign tick = run & ~clr & (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase two-road traffic-light controller with power gating, pause and
// emergency all-red override. Define GREEN_BLINK_EN to blink green in its last 3 s.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int NS_GREEN  = DEF_NS_GREEN,
    parameter int NS_YELLOW = DEF_NS_YELLOW,
    parameter int EW_GREEN  = DEF_EW_GREEN,
    parameter int EW_YELLOW = DEF_EW_YELLOW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic       pause,
    input  logic       emerg,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic [6:0] remain,
    output logic       sec_tick,
    output logic       cycle_done
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [6:0] NS_G_LD = 7'(NS_GREEN - 1);
    localparam logic [6:0] NS_Y_LD = 7'(NS_YELLOW - 1);
    localparam logic [6:0] EW_G_LD = 7'(EW_GREEN - 1);
    localparam logic [6:0] EW_Y_LD = 7'(EW_YELLOW - 1);

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       remain_nxt;
    logic             done_nxt;
    logic [5:0]       lamp_nxt;
    logic             run;
    logic             clr;
    logic             tick;
    logic [CNT_W-1:0] pre_count;

    function automatic logic [6:0] load_for(input state_t s);
        case (s)
            NS_G:    return NS_G_LD;
            NS_Y:    return NS_Y_LD;
            EW_G:    return EW_G_LD;
            EW_Y:    return EW_Y_LD;
            default: return 7'd0;
        endcase
    endfunction

    // Packed as {ns, ew}.
    function automatic logic [5:0] lamps_for(input state_t s);
        case (s)
            NS_G:    return {LAMP_G, LAMP_R};
            NS_Y:    return {LAMP_Y, LAMP_R};
            EW_G:    return {LAMP_R, LAMP_G};
            EW_Y:    return {LAMP_R, LAMP_Y};
            default: return {LAMP_R, LAMP_R};
        endcase
    endfunction

    // Power gating outranks everything, so clr is qualified by power to keep
    // the prescaler frozen while unpowered even if emerg is high.
    assign run = power & ~pause & (state != EMERG);
    assign clr = power & (emerg | (state == EMERG));

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .clr  (clr),
        .count(pre_count),
        .tick (tick)
    );

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        done_nxt   = 1'b0;
        if (power) begin
            if (emerg) begin
                state_nxt  = EMERG;
                remain_nxt = '0;
            end else if (state == EMERG) begin
                state_nxt  = NS_G;
                remain_nxt = NS_G_LD;
            end else if (tick) begin
                if (remain != '0) begin
                    remain_nxt = remain - 1'b1;
                end else begin
                    state_nxt  = next_phase(state);
                    remain_nxt = load_for(next_phase(state));
                    done_nxt   = (state == EW_Y);
                end
            end
        end
    end

`ifdef GREEN_BLINK_EN
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TICK_DIV / 2);
    logic [CNT_W-1:0] cnt_nxt;

    // Blink phase follows the prescaler value that will be held after this edge.
    always_comb begin
        cnt_nxt  = (tick | clr) ? '0 : (run ? pre_count + 1'b1 : pre_count);
        lamp_nxt = power ? lamps_for(state_nxt) : {LAMP_OFF, LAMP_OFF};
        if (power && (state_nxt == NS_G || state_nxt == EW_G) &&
            remain_nxt < 7'd3 && cnt_nxt >= HALF) begin
            lamp_nxt = lamp_nxt & ~{LAMP_G, LAMP_G};
        end
    end
`else
    always_comb begin
        lamp_nxt = power ? lamps_for(state_nxt) : {LAMP_OFF, LAMP_OFF};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= NS_G;
            remain     <= NS_G_LD;
            ns_light   <= LAMP_G;
            ew_light   <= LAMP_R;
            sec_tick   <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state                <= state_nxt;
            remain               <= remain_nxt;
            {ns_light, ew_light} <= lamp_nxt;
            sec_tick             <= tick;
            cycle_done           <= done_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer at TICK_DIV=10 with default durations.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       power = 1'b1;
    logic       pause = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic [6:0] remain;
    logic       sec_tick;
    logic       cycle_done;

    phase_sequencer #(.TICK_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .power     (power),
        .pause     (pause),
        .emerg     (emerg),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase),
        .remain    (remain),
        .sec_tick  (sec_tick),
        .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [2:0] ph;
        logic [6:0] rem;
        logic       cd;
        logic [2:0] ns;
        logic [2:0] ew;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t = 0;
    int   next_at = 10;

    // Active edges since the most recent reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Seconds position t in the 40 s cycle after a tick fixes phase/remain/lamps.
    task automatic push_tick();
        exp_t e;
        t = (t + 1) % 40;
        e.at = next_at;
        e.cd = (t == 0);
        if (t < 15) begin
            e.ph = 3'd0; e.rem = 7'(14 - t); e.ns = 3'b001; e.ew = 3'b100;
        end else if (t < 20) begin
            e.ph = 3'd1; e.rem = 7'(19 - t); e.ns = 3'b010; e.ew = 3'b100;
        end else if (t < 35) begin
            e.ph = 3'd2; e.rem = 7'(34 - t); e.ns = 3'b100; e.ew = 3'b001;
        end else begin
            e.ph = 3'd3; e.rem = 7'(39 - t); e.ns = 3'b100; e.ew = 3'b010;
        end
        q.push_back(e);
        next_at += 10;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push_tick();
    endtask

    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [2:0] ns, input logic [2:0] ew,
                             input logic [2:0] ph, input logic [6:0] rem);
        check({name, ".ns"}, ns_light, ns);
        check({name, ".ew"}, ew_light, ew);
        check({name, ".phase"}, phase, ph);
        check({name, ".remain"}, remain, rem);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (sec_tick) begin
                if (q.size() == 0) begin
                    check("unexpected sec_tick", sec_tick, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("tick.edge", cyc, mon_e.at);
                    check("tick.phase", phase, mon_e.ph);
                    check("tick.remain", remain, mon_e.rem);
                    check("tick.cycle_done", cycle_done, mon_e.cd);
                    check("tick.ns", ns_light, mon_e.ns);
                    check("tick.ew", ew_light, mon_e.ew);
                end
            end else if (cycle_done) begin
                check("stray cycle_done", cycle_done, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: edge %0d, required completion well before this", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        check_out("reset", 3'b001, 3'b100, 3'd0, 7'd14);
        check("reset.sec_tick", sec_tick, 0);
        check("reset.cycle_done", cycle_done, 0);
        @(negedge clk);
        reset = 1'b1;

        // One full 40 s cycle.
        push_n(40);
        goto(400);
        check_out("cycle_end", 3'b001, 3'b100, 3'd0, 7'd14);

        // Pause 37 cycles mid-EW_G with the prescaler at 5.
        push_n(24);
        goto(645);
        pause = 1'b1;
        next_at += 37;
        push_n(33);
        goto(670);
        check_out("paused", 3'b100, 3'b001, 3'd2, 7'd10);
        check("paused.sec_tick", sec_tick, 0);
        goto(682);
        pause = 1'b0;
        goto(683);
        check_out("unpaused", 3'b100, 3'b001, 3'd2, 7'd10);

        // Emergency pulse during NS_Y with remain 2.
        goto(1008);
        check_out("pre_emerg", 3'b010, 3'b100, 3'd1, 7'd2);
        goto(1010);
        emerg = 1'b1;
        goto(1011);
        check_out("emerg", 3'b100, 3'b100, 3'd4, 7'd0);
        goto(1013);
        emerg = 1'b0;
        goto(1014);
        check_out("emerg_exit", 3'b001, 3'b100, 3'd0, 7'd14);
        t = 0;
        next_at = 1024;

        // Power off for 50 cycles in EW_Y with the prescaler at 3.
        push_n(36);
        goto(1377);
        power = 1'b0;
        goto(1378);
        check_out("power_off", 3'b000, 3'b000, 3'd3, 7'd3);
        goto(1420);
        check_out("power_off_late", 3'b000, 3'b000, 3'd3, 7'd3);
        goto(1427);
        power = 1'b1;
        goto(1428);
        check_out("power_on", 3'b100, 3'b010, 3'd3, 7'd3);
        next_at += 50;

        // Emergency lands on the edge that would end EW_Y.
        push_n(3);
        goto(1463);
        emerg = 1'b1;
        goto(1464);
        check_out("emerg_on_tick", 3'b100, 3'b100, 3'd4, 7'd0);
        check("emerg_on_tick.sec_tick", sec_tick, 0);
        check("emerg_on_tick.cycle_done", cycle_done, 0);
        emerg = 1'b0;
        goto(1465);
        check_out("emerg_on_tick_exit", 3'b001, 3'b100, 3'd0, 7'd14);
        t = 0;
        next_at = 1475;

        // Asynchronous reset between edges mid-EW_G.
        push_n(24);
        goto(1708);
        check_out("pre_reset", 3'b100, 3'b001, 3'd2, 7'd10);
        #2 reset = 1'b0;
        #1;
        check_out("async_reset", 3'b001, 3'b100, 3'd0, 7'd14);
        check("async_reset.sec_tick", sec_tick, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        t = 0;
        next_at = 10;
        push_n(2);
        goto(25);
        check("scoreboard drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Four-phase two-road traffic-light controller with an integrated 1-second tick generator. It sequences NS green/yellow and EW green/yellow over a 40 s cycle, exposes the remaining seconds of the current phase for the seven-segment display path, and supports power gating, pause and an emergency all-red override. It sits between the board-level switch inputs and the lamp/display drivers.

## Interface
- TICK_DIV, 1000000: clk cycles per 1 s tick; legal range ≥ 2.
- NS_GREEN, 15: NS green duration in seconds; legal range 1..127.
- NS_YELLOW, 5: NS yellow duration in seconds; legal range 1..127.
- EW_GREEN, 15: EW green duration in seconds; legal range 1..127.
- EW_YELLOW, 5: EW yellow duration in seconds; legal range 1..127.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- power  in  1  1 = run; 0 = lamps off, all counters frozen.
- pause  in  1  1 = freeze prescaler and remain; lamps hold.
- emerg  in  1  level request for the all-red override.
- ns_light  out  3  {R,Y,G}, one-hot when powered, 000 when unpowered.
- ew_light  out  3  {R,Y,G}, same rules as ns_light.
- phase  out  3  state code from the package.
- remain  out  7  seconds left in the phase, minus one (counts N-1..0).
- sec_tick  out  1  one-cycle pulse per elapsed second.
- cycle_done  out  1  one-cycle pulse when EW_Y ends.

## Operation
- States: NS_G, NS_Y, EW_G, EW_Y, EMERG. Normal order: NS_G→NS_Y→EW_G→EW_Y→NS_G.
- Lamps per state:
  - NS_G: NS=G, EW=R.
  - NS_Y: NS=Y, EW=R.
  - EW_G: NS=R, EW=G.
  - EW_Y: NS=R, EW=Y.
  - EMERG: both R.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run = power & ~pause & ~emerg-state.
  - At TICK_DIV-1 with run=1, it wraps to 0 and sec_tick=1 for that cycle.
- On sec_tick:
  - remain≠0: remain decrements.
  - remain==0: advance to the next state and load the next duration-1.
- cycle_done is asserted on the same cycle as the sec_tick that leaves EW_Y.
- Priority, highest first: reset > power=0 > emerg > pause > normal.
- power=0:
  - State, remain and prescaler hold.
  - Lamps read 000; sec_tick and cycle_done are 0.
  - On power return, operation resumes exactly where it stopped.
- emerg=1 (with power=1): the next edge enters EMERG, prescaler←0, remain←0.
- emerg falling:
  - The next edge enters NS_G, remain←NS_GREEN-1, prescaler←0.
  - The interrupted phase is discarded.
- pause=1 in EMERG has no effect. If emerg and pause are both high, EMERG wins.
- Durations are unsigned 7-bit. Duration-1 is computed at elaboration.

## Timing
- Reset values:
  - state NS_G, remain NS_GREEN-1, prescaler 0.
  - ns_light 001, ew_light 100.
  - sec_tick 0, cycle_done 0.
- Outputs are registered; one cycle of latency from any input change to lamps/phase.
- First sec_tick after reset release with power=1 and pause=0: TICK_DIV cycles after the first active edge.
- Full cycle with defaults: 40 ticks = 40·TICK_DIV cycles.
- pause is sampled every cycle. On release, the prescaler continues from its held value, with no extra tick.
- emerg asserted on the same cycle as a pending sec_tick: EMERG wins, no tick, no cycle_done.

## Configuration
- GREEN_BLINK_EN defined:
  - While in NS_G or EW_G with remain<3 and power=1, the green lamp is on only while prescaler<TICK_DIV/2.
  - The lamp is 000 for the road with green during the other half.
  - Red lamps are unaffected.
- Undefined: green is steady for the full phase.

## Structure
- Package seq_pkg:
  - State enum with 3-bit codes: NS_G=0, NS_Y=1, EW_G=2, EW_Y=3, EMERG=4.
  - Lamp constants LAMP_R=100, LAMP_Y=010, LAMP_G=001, LAMP_OFF=000.
  - Default duration constants.
- Sub-module tick_prescaler:
  - Parameter TICK_DIV.
  - Inputs clk, reset, run, clr.
  - Outputs count and tick.
- The top level holds the state register, the remain down-counter and the lamp decode.

## Test plan
All scenarios run with TICK_DIV=10 and default durations.
- Reset then power=1:
  - First sec_tick at cycle 10, remain 14→13.
  - NS_Y entered at tick 15 with remain=4.
- Run 40 ticks: one cycle_done, at cycle 400. State then NS_G, remain=14, with the order NS_G/NS_Y/EW_G/EW_Y verified.
- pause for 37 cycles mid-EW_G:
  - remain and prescaler hold.
  - The next tick is delayed by exactly 37 cycles.
  - Lamps are unchanged.
- emerg pulse during NS_Y at remain=2:
  - Both lamps go to 100 one cycle later.
  - After release, NS_G with remain=14 and prescaler=0.
- power=0 for 50 cycles in EW_Y:
  - Lamps read 000.
  - No ticks occur.
  - After power=1, the same remain/prescaler resume.
- Async reset asserted mid-EW_G between edges: outputs return to reset values immediately. With GREEN_BLINK_EN, NS green toggles at remain 2..0 (5 on / 5 off).
